// File: rtl/sequential_divider_pkg.sv
// Shared definitions for the sequential divider: default operand width,
// controller state encoding and the iteration-counter width helper.
package sequential_divider_pkg;

    localparam int DIV_N = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Counter must hold the value 2N (number of quotient bits).
    function automatic int cnt_width(input int n);
        return $clog2(2 * n + 1);
    endfunction

endpackage

// File: rtl/sequential_divider_if.sv
// Host-side start/done handshake and operand/result bus of the divider.
interface sequential_divider_if
    import sequential_divider_pkg::*;
#(
    parameter int N = DIV_N
) ();

    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [2*N-1:0]   quotient;
    logic [N-1:0]     remainder;
    logic [1:0]       state_dbg;

    modport master (
        output start, dividend, divisor,
        input  busy, done, div_by_zero, quotient, remainder, state_dbg
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, div_by_zero, quotient, remainder, state_dbg
    );

endinterface

// File: rtl/sequential_divider_datapath.sv
// Restoring-division datapath: partial remainder, dividend/quotient shift
// register, latched divisor, trial subtractor and held result registers.
module divider_datapath
    import sequential_divider_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,        // capture operands, clear remainder
    input  logic           step,        // one shift/trial-subtract iteration
    input  logic           zero_load,   // divide-by-zero result
    input  logic           result_ld,   // final iteration: publish results
    input  logic           keep_rem,    // controller decision: restore (trial was negative)
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           trial_neg,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero
);

    // The stored remainder is always below the divisor, so N bits suffice;
    // only the shifted value needs the extra bit (it can reach 2D-1).
    logic [N-1:0]   rem_r;
    logic [2*N-1:0] q_r;
    logic [N-1:0]   d_r;
    logic [N:0]     rem_shift_s;
    logic [N:0]     trial_s;
    logic [N-1:0]   rem_next_s;
    logic [2*N-1:0] q_next_s;
    logic [2*N-1:0] quotient_r;
    logic [N-1:0]   remainder_r;
    logic           dbz_r;

    // Shift, trial subtraction and selection of the next remainder/quotient bit.
    always_comb begin
        rem_shift_s = {rem_r, q_r[2*N-1]};
        trial_s     = rem_shift_s - {1'b0, d_r};
        if (keep_rem) begin
            rem_next_s = rem_shift_s[N-1:0];
            q_next_s   = {q_r[2*N-2:0], 1'b0};
        end else begin
            rem_next_s = trial_s[N-1:0];
            q_next_s   = {q_r[2*N-2:0], 1'b1};
        end
    end

    assign trial_neg = trial_s[N];

    // Working registers: operand capture and per-cycle iteration.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_r <= {N{1'b0}};
            q_r   <= {(2*N){1'b0}};
            d_r   <= {N{1'b0}};
        end else if (load) begin
            rem_r <= {N{1'b0}};
            q_r   <= dividend;
            d_r   <= divisor;
        end else if (step) begin
            rem_r <= rem_next_s;
            q_r   <= q_next_s;
        end else begin
            rem_r <= rem_r;
            q_r   <= q_r;
        end
    end

    // Result registers: written only on DONE entry, held until the next accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            quotient_r  <= {(2*N){1'b0}};
            remainder_r <= {N{1'b0}};
            dbz_r       <= 1'b0;
        end else if (zero_load) begin
            quotient_r  <= {(2*N){1'b1}};
            remainder_r <= {N{1'b0}};
            dbz_r       <= 1'b1;
        end else if (result_ld) begin
            quotient_r  <= q_next_s;
            remainder_r <= rem_next_s;
        end else if (load) begin
            dbz_r       <= 1'b0;
        end else begin
            dbz_r       <= dbz_r;
        end
    end

    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule

// File: rtl/sequential_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one
// quotient bit per clock, with IDLE/RUN/DONE controller and start/done handshake.
module sequential_divider
    import sequential_divider_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic               clk,
    input  logic               reset,
    sequential_divider_if.slave bus
);

    localparam int CNT_W = cnt_width(N);

    div_state_e       state_r;
    div_state_e       state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             busy_r;
    logic             done_r;
    logic             load_s;
    logic             step_s;
    logic             zero_load_s;
    logic             result_ld_s;
    logic             trial_neg_s;

    // Next-state, counter and datapath control decode.
    always_comb begin
        state_next_s = ST_IDLE;
        cnt_next_s   = cnt_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        zero_load_s  = 1'b0;
        result_ld_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.divisor != {N{1'b0}}) begin
                        load_s       = 1'b1;
                        cnt_next_s   = CNT_W'(2 * N);
                        state_next_s = ST_RUN;
                    end else begin
                        zero_load_s  = 1'b1;
                        state_next_s = ST_DONE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                step_s     = 1'b1;
                cnt_next_s = cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    result_ld_s  = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered busy/done flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            busy_r  <= (state_next_s == ST_RUN);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    divider_datapath #(
        .N (N)
    ) u_datapath (
        .clk         (clk),
        .reset       (reset),
        .load        (load_s),
        .step        (step_s),
        .zero_load   (zero_load_s),
        .result_ld   (result_ld_s),
        .keep_rem    (trial_neg_s),
        .dividend    (bus.dividend),
        .divisor     (bus.divisor),
        .trial_neg   (trial_neg_s),
        .quotient    (bus.quotient),
        .remainder   (bus.remainder),
        .div_by_zero (bus.div_by_zero)
    );

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.state_dbg = state_r;

endmodule
